// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: fetches aligned 32-bit words, splits them into
// halfwords and queues them for the compressed decoder, with redirect flush.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     fifo_q [DEPTH];
  logic [15:0]     fifo_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic            drop_low_q, drop_low_d;

  logic            push_lo_c;
  logic            push_hi_c;
  logic            pop_c;
  logic            unused_pc_bit;

  // Halfword address bit 0 carries no information for 16-bit aligned PCs.
  assign unused_pc_bit = redirect_pc[0];

  // A response is only accepted for the live request; redirect squashes it.
  assign push_hi_c = (state_q == S_WAIT) && mem_rvalid && !redirect_valid;
  assign push_lo_c = push_hi_c && !drop_low_q;
  assign pop_c     = (count_q != '0) && inst_ready && !redirect_valid;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request is only issued with two free slots
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid || (count_q <= CW'(DEPTH - 2))) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = redirect_valid ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = mem_rvalid ? S_IDLE : S_DISCARD;
        end else if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO, PC and fetch-address update; redirect overrides push and pop
  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    inst_pc_d    = inst_pc_q;
    drop_low_d   = drop_low_q;
    if (redirect_valid) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      inst_pc_d    = {redirect_pc[31:1], 1'b0};
      drop_low_d   = redirect_pc[1];
    end else begin
      if (push_lo_c) begin
        fifo_d[wr_ptr_d] = mem_rdata[15:0];
        wr_ptr_d         = wr_ptr_d + AW'(1);
      end
      if (push_hi_c) begin
        fifo_d[wr_ptr_d] = mem_rdata[31:16];
        wr_ptr_d         = wr_ptr_d + AW'(1);
        drop_low_d       = 1'b0;
        fetch_addr_d     = fetch_addr_q + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        inst_pc_d = inst_pc_q + 32'd2;
      end
      count_d = count_q + CW'(push_lo_c) + CW'(push_hi_c) - CW'(pop_c);
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      inst_pc_q    <= {RESET_PC[31:1], 1'b0};
      drop_low_q   <= RESET_PC[1];
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      inst_pc_q    <= inst_pc_d;
      drop_low_q   <= drop_low_d;
    end
  end

  // Outputs decoded from registered state and FIFO storage only
  always_comb begin
    mem_req    = (state_q == S_REQ);
    mem_addr   = fetch_addr_q;
    inst_valid = (count_q != '0);
    inst       = fifo_q[rd_ptr_q];
    inst_pc    = inst_pc_q;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer: a latency-configurable
// memory responder plus a second instance that starts at the top of memory.
module tb_fetch_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_mem_gnt;
  logic        w_mem_rvalid = 1'b0;
  logic [31:0] w_mem_rdata = 32'd0;
  logic        w_inst_valid;
  logic [15:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_inst_ready = 1'b1;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'd0;

  int          errors = 0;
  int          checks = 0;

  int unsigned mem_lat = 1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_addr = 32'd0;
  logic [31:0] ovr_data = 32'd0;
  int unsigned pend_cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  logic        w_pend = 1'b0;
  logic [31:0] w_paddr = 32'd0;
  logic        saw_junk = 1'b0;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clock(clock), .reset(reset),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_gnt(w_mem_gnt),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_ready(w_inst_ready),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  initial forever #5 clock = ~clock;

  // Default memory image: the halfword at address a holds a[15:0]^16'h1000.
  function automatic logic [31:0] dflt_word(input logic [31:0] a);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = a[15:0] ^ 16'h1000;
    hi = (a[15:0] + 16'd2) ^ 16'h1000;
    return {hi, lo};
  endfunction

  assign mem_gnt   = mem_req;
  assign w_mem_gnt = w_mem_req;

  // Main memory responder, latency mem_lat cycles after grant.
  initial forever begin
    @(negedge clock);
    mem_rvalid = 1'b0;
    if (reset) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt != 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (ovr_en && pend_addr == ovr_addr) ? ovr_data : dflt_word(pend_addr);
        end
      end
      if (mem_req && mem_gnt) begin
        pend_cnt  = mem_lat;
        pend_addr = mem_addr;
      end
    end
  end

  // Wrap-instance responder, fixed 1-cycle latency.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      w_pend       = 1'b0;
      w_mem_rvalid = 1'b0;
    end else begin
      w_mem_rvalid = w_pend;
      w_mem_rdata  = dflt_word(w_paddr);
      w_pend       = w_mem_req && w_mem_gnt;
      w_paddr      = w_mem_addr;
    end
  end

  initial forever begin
    @(negedge clock);
    #2;
    if (inst_valid && (inst == 16'hDEAD || inst == 16'hBEEF)) saw_junk = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic ready);
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    inst_ready     = ready;
    reset          = 1'b1;
    step();
    step();
    reset          = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (inst_valid) break;
      step();
    end
  endtask

  task automatic test_reset();
    inst_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    checks++; if (inst !== 16'd0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
    checks++; if (w_mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_w_addr got=%h exp=fffffffc", w_mem_addr); end
    checks++; if (w_inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_w_pc got=%h exp=fffffffc", w_inst_pc); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    ovr_en = 1'b1; ovr_addr = 32'd0; ovr_data = 32'h4505_4581; mem_lat = 1;
    apply_reset(1'b1);
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL basic_addr got=%h exp=0", mem_addr); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%b exp=0", inst_valid); end
    step();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0 got=%b exp=1", inst_valid); end
    checks++; if (inst !== 16'h4581) begin errors++; $display("FAIL basic_inst0 got=%h exp=4581", inst); end
    checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL basic_pc0 got=%h exp=0", inst_pc); end
    step();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1 got=%b exp=1", inst_valid); end
    checks++; if (inst !== 16'h4505) begin errors++; $display("FAIL basic_inst1 got=%h exp=4505", inst); end
    checks++; if (inst_pc !== 32'd2) begin errors++; $display("FAIL basic_pc1 got=%h exp=2", inst_pc); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req2 got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'd4) begin errors++; $display("FAIL basic_addr2 got=%h exp=4", mem_addr); end
  endtask

  task automatic test_backpressure();
    int ngrant;
    ngrant = 0;
    ovr_en = 1'b1; ovr_addr = 32'd0; ovr_data = 32'h4505_4581; mem_lat = 1;
    apply_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_req && mem_gnt) ngrant++;
    end
    checks++; if (ngrant !== 2) begin errors++; $display("FAIL bp_grants got=%0d exp=2", ngrant); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got=%b exp=0", mem_req); end
    checks++; if (inst !== 16'h4581 || inst_pc !== 32'd0) begin errors++; $display("FAIL bp_head got=%h/%h exp=4581/0", inst, inst_pc); end
    inst_ready = 1'b1;
    step();
    step();
    inst_ready = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_count3 got=%b exp=0", mem_req); end
    checks++; if (inst !== 16'h1004 || inst_pc !== 32'd4) begin errors++; $display("FAIL bp_head2 got=%h/%h exp=1004/4", inst, inst_pc); end
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL bp_req_count2 got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'd8) begin errors++; $display("FAIL bp_addr got=%h exp=8", mem_addr); end
  endtask

  task automatic test_redirect_full();
    ovr_en = 1'b0; mem_lat = 1;
    apply_reset(1'b0);
    for (int i = 0; i < 12; i++) step();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rf_full_valid got=%b exp=1", inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0106;
    step();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rf_flush got=%b exp=0", inst_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin errors++; $display("FAIL rf_req got=%b/%h exp=1/104", mem_req, mem_addr); end
    checks++; if (inst_pc !== 32'h106) begin errors++; $display("FAIL rf_pc got=%h exp=106", inst_pc); end
    inst_ready = 1'b1;
    wait_valid(10);
    checks++; if (inst_valid !== 1'b1 || inst !== 16'h1106 || inst_pc !== 32'h106) begin
      errors++; $display("FAIL rf_first got=%b/%h/%h exp=1/1106/106", inst_valid, inst, inst_pc);
    end
    step();
    wait_valid(10);
    checks++; if (inst_valid !== 1'b1 || inst !== 16'h1108 || inst_pc !== 32'h108) begin
      errors++; $display("FAIL rf_second got=%b/%h/%h exp=1/1108/108", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_redirect_wait();
    ovr_en = 1'b1; ovr_addr = 32'd0; ovr_data = 32'hDEAD_BEEF; mem_lat = 3;
    apply_reset(1'b1);
    saw_junk = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL rw_req got=%b/%h exp=1/0", mem_req, mem_addr); end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_discard got=%b/%b exp=0/0", mem_req, inst_valid); end
    for (int i = 0; i < 20; i++) begin
      if (mem_req) break;
      step();
    end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rw_newreq got=%b/%h exp=1/40", mem_req, mem_addr); end
    wait_valid(20);
    checks++; if (inst_valid !== 1'b1 || inst !== 16'h1040 || inst_pc !== 32'h40) begin
      errors++; $display("FAIL rw_inst got=%b/%h/%h exp=1/1040/40", inst_valid, inst, inst_pc);
    end
    step();
    checks++; if (saw_junk !== 1'b0) begin errors++; $display("FAIL rw_late_data got=%b exp=0", saw_junk); end
    mem_lat = 1; ovr_en = 1'b0;
  endtask

  task automatic test_redirect_rvalid();
    ovr_en = 1'b0; mem_lat = 1;
    apply_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_rvalid && inst_valid) break;
    end
    checks++; if (mem_rvalid !== 1'b1 || inst_valid !== 1'b1) begin errors++; $display("FAIL rr_setup got=%b/%b exp=1/1", mem_rvalid, inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got=%b exp=0", inst_valid); end
    checks++; if (inst_pc !== 32'h200) begin errors++; $display("FAIL rr_no_pop got=%h exp=200", inst_pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b exp=0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL rr_req got=%b/%h exp=1/200", mem_req, mem_addr); end
    wait_valid(10);
    checks++; if (inst_valid !== 1'b1 || inst !== 16'h1200 || inst_pc !== 32'h200) begin
      errors++; $display("FAIL rr_inst got=%b/%h/%h exp=1/1200/200", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      if (w_inst_valid) break;
      step();
    end
    checks++; if (w_inst_valid !== 1'b1 || w_inst !== 16'hEFFC || w_inst_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_i0 got=%b/%h/%h exp=1/effc/fffffffc", w_inst_valid, w_inst, w_inst_pc);
    end
    step();
    checks++; if (w_inst !== 16'hEFFE || w_inst_pc !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL wrap_i1 got=%h/%h exp=effe/fffffffe", w_inst, w_inst_pc);
    end
    checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'd0) begin errors++; $display("FAIL wrap_addr got=%b/%h exp=1/0", w_mem_req, w_mem_addr); end
    step();
    checks++; if (w_inst_valid !== 1'b0 || w_inst_pc !== 32'd0) begin errors++; $display("FAIL wrap_pc got=%b/%h exp=0/0", w_inst_valid, w_inst_pc); end
    for (int i = 0; i < 10; i++) begin
      if (w_inst_valid) break;
      step();
    end
    checks++; if (w_inst_valid !== 1'b1 || w_inst !== 16'h1000 || w_inst_pc !== 32'd0) begin
      errors++; $display("FAIL wrap_i2 got=%b/%h/%h exp=1/1000/0", w_inst_valid, w_inst, w_inst_pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_full();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage directly upstream of the RV32C decoder; replaces the direct combinational pmem lookup in cpu.
- Fetches aligned 32-bit words from instruction memory through a request/grant/response handshake.
- Splits each word into two 16-bit compressed instructions and queues them in a halfword FIFO.
- Presents one instruction per cycle with its PC via valid/ready; supports a redirect (jump/branch) that flushes the FIFO and restarts fetch.

Parameters:
- DEPTH, 4, FIFO capacity in halfwords; power of two, minimum 2.
- RESET_PC, 32'd0, fetch PC after reset; bit 0 is ignored.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  output  1  word fetch request.
- mem_addr  output  32  word address; bits 1:0 always 0.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid; in order, earliest 1 cycle after grant.
- mem_rdata  input  32  read word; [15:0] is at mem_addr, [31:16] is at mem_addr+2.
- inst_valid  output  1  head of FIFO is valid.
- inst  output  16  head instruction.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  decoder consumes the head this cycle.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new PC; bit 0 is ignored.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, FIFO empty (count=0).
  - fetch_addr={RESET_PC[31:2],2'b00}; inst_pc={RESET_PC[31:1],1'b0}; drop_low=RESET_PC[1].
  - mem_req=0, inst_valid=0, inst=0.
- States: IDLE, REQ, WAIT, DISCARD. mem_req=1 only in REQ; mem_addr=fetch_addr.
- Transitions:
  - IDLE->REQ when count<=DEPTH-2, evaluated on the registered count.
  - REQ->WAIT on mem_gnt. mem_req and mem_addr are held stable until grant, except on redirect.
  - WAIT->IDLE on mem_rvalid.
- Push on mem_rvalid in WAIT:
  - Push the low halfword unless drop_low=1; always push the high halfword.
  - Clear drop_low; fetch_addr+=4, wrapping modulo 2^32.
- Pop on inst_valid && inst_ready: inst_pc+=2, wrapping modulo 2^32.
- Simultaneous push and pop are both honoured: count_next = count + pushed - popped.
- Overflow cannot occur, because a request is only issued with at least 2 free slots and only one request is outstanding.
- Outputs are registered from FIFO storage. mem_rvalid at cycle M gives inst_valid at M+1 when the FIFO was empty; there is no bypass.
- Redirect (redirect_valid=1) takes priority over push and pop in the same cycle:
  - FIFO is emptied; the pop is ignored; inst_valid=0 next cycle.
  - inst_pc={redirect_pc[31:1],0}; fetch_addr={redirect_pc[31:2],00}; drop_low=redirect_pc[1].
  - IDLE: ->REQ next cycle with the new address.
  - REQ: stays REQ with the new address; a grant in the same cycle is treated as a grant of the old request, so ->DISCARD.
  - WAIT: ->DISCARD; a mem_rvalid in the same cycle drops the data and goes ->IDLE.
  - DISCARD: stays DISCARD and takes the new PC.
- DISCARD->IDLE on mem_rvalid; the response data is dropped and fetch_addr is not incremented.
- Latency: redirect at cycle N with no request outstanding gives mem_req=1 at cycle N+1.
- Reset mid-transaction returns to the reset state immediately. The memory must not deliver a response for a request granted before reset.

Test Plan:
- Reset with RESET_PC=0, memory word0=32'h4505_4581, 1-cycle latency, inst_ready=1:
  - mem_req at cycle 1 with mem_addr=0.
  - inst=16'h4581 with pc=0, then inst=16'h4505 with pc=2, on consecutive cycles.
- Backpressure: inst_ready=0 with DEPTH=4:
  - Exactly 2 words fetched, count=4, mem_req stays 0.
  - inst_ready=1 for 2 cycles gives a new mem_req once count=2.
- Redirect to redirect_pc=32'h0000_0106 while the FIFO is full:
  - Next cycle inst_valid=0 and mem_addr=32'h104.
  - The low halfword is dropped; the first inst is word[31:16] with inst_pc=32'h106.
- Redirect in WAIT with a 3-cycle memory latency:
  - The late response (data 32'hDEAD_BEEF) never appears on inst.
  - The next mem_req uses the redirect address.
- Redirect in the same cycle as mem_rvalid and inst_ready: the response is dropped, no pop occurs, and the FIFO is empty next cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC gives insts at pc FFFF_FFFC and FFFF_FFFE, then mem_addr=0 with inst_pc=0.
